// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC at 0xFF04-0xFF07, with TIMA overflow reload and interrupt request.
// Define GB_TIMER_OVF_DELAY_EN for the DMG-accurate 4-cycle delayed reload and its cancel window.
`timescale 1ns / 1ps
module gb_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        hit,
    output logic        irq_timer
);

    localparam logic [1:0] RegDiv  = 2'd0;
    localparam logic [1:0] RegTima = 2'd1;
    localparam logic [1:0] RegTma  = 2'd2;
    localparam logic [1:0] RegTac  = 2'd3;

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_q, tick;
    logic        irq_q, irq_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic        wr_div, wr_tima, wr_tma, wr_tac;
    logic        tap, inc, tima_ovf;
    logic [7:0]  tma_new;

    assign hit = (addr[15:2] == 14'h3FC1);

    assign wr_div  = wr_en & hit & (addr[1:0] == RegDiv);
    assign wr_tima = wr_en & hit & (addr[1:0] == RegTima);
    assign wr_tma  = wr_en & hit & (addr[1:0] == RegTma);
    assign wr_tac  = wr_en & hit & (addr[1:0] == RegTac);

    // A reload in the same cycle as a TMA write takes the value being written.
    assign tma_new = wr_tma ? wr_data : tma_q;

    always_comb begin
        case (tac_q[1:0])
            2'b00: tap = div_q[9];
            2'b01: tap = div_q[3];
            2'b10: tap = div_q[5];
            2'b11: tap = div_q[7];
        endcase
    end

    // Falling-edge detect on the gated tap keeps the DIV-write and TAC-change glitches.
    assign tick     = tac_q[2] & tap;
    assign inc      = tick_q & ~tick;
    assign tima_ovf = inc & (tima_q == 8'hFF);

    assign div_d = wr_div ? 16'h0000 : div_q + 16'd1;
    assign tma_d = tma_new;
    assign tac_d = wr_tac ? wr_data[2:0] : tac_q;

`ifdef GB_TIMER_OVF_DELAY_EN
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDelay  = 2'd1;
    localparam logic [1:0] StReload = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] dly_q, dly_d;

    always_comb begin
        tima_d  = tima_q;
        state_d = state_q;
        dly_d   = dly_q;
        irq_d   = 1'b0;
        unique case (state_q)
            StDelay: begin
                if (wr_tima) begin
                    tima_d  = wr_data;
                    state_d = StIdle;
                end else if (tima_ovf) begin
                    tima_d = 8'h00;
                    dly_d  = 2'd0;
                end else if (dly_q == 2'd3) begin
                    tima_d  = tma_new;
                    state_d = StReload;
                    irq_d   = 1'b1;
                end else begin
                    dly_d = dly_q + 2'd1;
                    if (inc) tima_d = tima_q + 8'd1;
                end
            end
            StReload: begin
                // CPU writes to TIMA are dropped; TMA (possibly just written) wins.
                tima_d  = tma_new;
                state_d = StIdle;
            end
            default: begin
                if (wr_tima) begin
                    tima_d = wr_data;
                end else if (inc) begin
                    tima_d = tima_q + 8'd1;
                    if (tima_q == 8'hFF) begin
                        state_d = StDelay;
                        dly_d   = 2'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            dly_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end
`else
    always_comb begin
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (wr_tima) begin
            tima_d = wr_data;
        end else if (tima_ovf) begin
            tima_d = tma_new;
            irq_d  = 1'b1;
        end else if (inc) begin
            tima_d = tima_q + 8'd1;
        end
    end
`endif

    // Read data reflects register state before any same-cycle write.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            if (hit) begin
                rd_valid_d = 1'b1;
                case (addr[1:0])
                    RegDiv:  rd_data_d = div_q[15:8];
                    RegTima: rd_data_d = tima_q;
                    RegTma:  rd_data_d = tma_q;
                    RegTac:  rd_data_d = {5'b11111, tac_q};
                endcase
            end else begin
                rd_data_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= 16'h0000;
            tima_q     <= 8'h00;
            tma_q      <= 8'h00;
            tac_q      <= 3'b000;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            rd_data_q  <= 8'hFF;
            rd_valid_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            tima_q     <= tima_d;
            tma_q      <= tma_d;
            tac_q      <= tac_d;
            tick_q     <= tick;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign irq_timer = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer; read expectations are queued at issue and popped on rd_valid.
`timescale 1ns / 1ps
module tb_gb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        hit;
    logic        irq_timer;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

`ifdef GB_TIMER_OVF_DELAY_EN
    localparam int IrqK = 21;
`else
    localparam int IrqK = 17;
`endif

    always #5 clk = ~clk;

    gb_timer dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .hit       (hit),
        .irq_timer (irq_timer)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every valid read pops one queued expectation.
    always @(negedge clk) begin
        string tg;
        if (rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 16'(exp_q.size()), 16'd1);
            end else begin
                tg = tag_q.pop_front();
                check(tg, {8'h00, rd_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string tg);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(tg);
        step();
        rd_en = 1'b0;
    endtask

    // TIMA seen by a read sampled at edge k, counting the DIV clear as edge 0 and TAC=0x05 as edge 1.
    function automatic logic [7:0] exp_tima(input int k);
`ifdef GB_TIMER_OVF_DELAY_EN
        if (k <= 17) return 8'hFF;
        else if (k <= 21) return 8'h00;
        else return 8'hAB;
`else
        if (k <= 17) return 8'hFF;
        else return 8'hAB;
`endif
    endfunction

    initial begin
        addr    = 16'h0000;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        step();
        step();
        check("rst_rd_data", {8'h00, rd_data}, 16'h00FF);
        check("rst_rd_valid", 16'(rd_valid), 16'd0);
        check("rst_irq", 16'(irq_timer), 16'd0);
        rst = 1'b1;

        // Reset values and DIV rate
        repeat (256) step();
        rd(16'hFF04, 8'h01, "div_rate");
        rd(16'hFF07, 8'hF8, "tac_rst");
        rd(16'hFF05, 8'h00, "tima_rst");
        rd(16'hFF06, 8'h00, "tma_rst");
        wr(16'hFF04, 8'h5A);
        rd(16'hFF04, 8'h00, "div_clr");

        // TIMA rate at clk/16
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        repeat (64) step();
        rd(16'hFF05, 8'h04, "tima_rate");

        // Overflow, reload and IRQ
        wr(16'hFF07, 8'h00);
        wr(16'hFF06, 8'hAB);
        rd(16'hFF06, 8'hAB, "tma_wr");
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
        for (int k = 2; k <= 24; k++) begin
            rd(16'hFF05, exp_tima(k), $sformatf("ovf_tima_%0d", k));
            check($sformatf("ovf_irq_%0d", k), 16'(irq_timer), 16'(k == IrqK));
        end

        // TIMA write in the cancel window (or on the overflow edge) suppresses reload and IRQ
        wr(16'hFF07, 8'h00);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
`ifdef GB_TIMER_OVF_DELAY_EN
        repeat (17) step();
`else
        repeat (15) step();
`endif
        wr(16'hFF05, 8'h10);
        check("cancel_irq_w", 16'(irq_timer), 16'd0);
        for (int k = 0; k < 9; k++) begin
            rd(16'hFF05, 8'h10, $sformatf("cancel_tima_%0d", k));
            check($sformatf("cancel_irq_%0d", k), 16'(irq_timer), 16'd0);
        end

        // DIV write while the selected tap is high gives one extra increment
        wr(16'hFF07, 8'h00);
        wr(16'hFF05, 8'h20);
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h04);
        repeat (598) step();
        rd(16'hFF05, 8'h20, "glitch_pre");
        wr(16'hFF04, 8'h00);
        step();
        rd(16'hFF05, 8'h21, "glitch_inc");
        rd(16'hFF05, 8'h21, "glitch_once");

        // Decode and misses
        addr = 16'hFF08;
        #1 check("hit_ff08", 16'(hit), 16'd0);
        addr = 16'hFF04;
        #1 check("hit_ff04", 16'(hit), 16'd1);
        step();
        addr = 16'hFF07;
        #1 check("hit_ff07", 16'(hit), 16'd1);
        addr = 16'hFF03;
        #1 check("hit_ff03", 16'(hit), 16'd0);
        step();
        addr  = 16'hFF08;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("miss_valid", 16'(rd_valid), 16'd0);
        check("miss_data", {8'h00, rd_data}, 16'h00FF);
        wr(16'hFF09, 8'h00);
        wr(16'hFF0A, 8'h00);
        wr(16'hFF0B, 8'h00);
        rd(16'hFF05, 8'h21, "miss_tima");
        rd(16'hFF06, 8'hAB, "miss_tma");
        rd(16'hFF07, 8'hFC, "miss_tac");

        // Reset during a pending overflow
        wr(16'hFF07, 8'h00);
        wr(16'hFF05, 8'hFF);
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
`ifdef GB_TIMER_OVF_DELAY_EN
        repeat (17) step();
`else
        repeat (15) step();
`endif
        rst = 1'b0;
        #1;
        check("rst2_irq", 16'(irq_timer), 16'd0);
        check("rst2_rd_data", {8'h00, rd_data}, 16'h00FF);
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rst2_irq_%0d", k), 16'(irq_timer), 16'd0);
        end
        rd(16'hFF05, 8'h00, "rst2_tima");
        rd(16'hFF06, 8'h00, "rst2_tma");
        rd(16'hFF07, 8'hF8, "rst2_tac");

        step();
        step();
        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
